// File: rtl/design_mux.sv
// design_mux: sequenced pad multiplexer handing NUM_IO pads to one of NUM_DESIGNS user designs.
// Optional feature: define DESIGN_MUX_SEL_SYNC_EN for a two-flop synchroniser on design_sel.
module design_mux #(
  parameter int unsigned NUM_IO        = 42,
  parameter int unsigned NUM_DESIGNS   = 8,
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned SEL_STABLE    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned RST_HOLD      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst,
  input  logic [SEL_W-1:0]              design_sel,
  input  logic                          rst_override_n,
  input  logic                          io_rst_n,
  input  logic [NUM_DESIGNS*NUM_IO-1:0] dsn_out,
  input  logic [NUM_DESIGNS*NUM_IO-1:0] dsn_oe,
  input  logic [NUM_DESIGNS*NUM_IO-1:0] dsn_pu,
  input  logic [NUM_DESIGNS*NUM_IO-1:0] dsn_pd,
  input  logic [NUM_DESIGNS*NUM_IO-1:0] dsn_cs,
  output logic [NUM_IO-1:0]             io_out,
  output logic [NUM_IO-1:0]             io_oe,
  output logic [NUM_IO-1:0]             io_pu,
  output logic [NUM_IO-1:0]             io_pd,
  output logic [NUM_IO-1:0]             io_cs,
  output logic [NUM_DESIGNS-1:0]        design_rst_n,
  output logic [SEL_W-1:0]              active_sel,
  output logic                          busy
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > RST_HOLD) ? SETTLE_CYCLES : RST_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned STB_W   = $clog2(SEL_STABLE + 1);

  typedef enum logic [1:0] {SAFE, ARM, RUN} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]        active_q, active_d;
  logic [SEL_W-1:0]        stable_q, stable_d;
  logic [SEL_W-1:0]        cand_q, cand_d;
  logic [STB_W-1:0]        stb_cnt_q, stb_cnt_d;
  logic [SEL_W-1:0]        sel_s;
  logic [NUM_IO-1:0]       io_out_q, io_out_d, io_oe_q, io_oe_d, io_pu_q, io_pu_d;
  logic [NUM_IO-1:0]       io_pd_q, io_pd_d, io_cs_q, io_cs_d;
  logic [NUM_DESIGNS-1:0]  rstn_q, rstn_d;
  logic                    in_range;

`ifdef DESIGN_MUX_SEL_SYNC_EN
  logic [SEL_W-1:0] sync1_q, sync2_q;
  assign sel_s = sync2_q;
`else
  assign sel_s = design_sel;
`endif

  // Stability counter saturates at SEL_STABLE; stable_sel reloads each cycle while saturated.
  always_comb begin
    cand_d = sel_s;
    if (sel_s != cand_q) begin
      stb_cnt_d = STB_W'(1);
    end else if (stb_cnt_q != STB_W'(SEL_STABLE)) begin
      stb_cnt_d = stb_cnt_q + 1'b1;
    end else begin
      stb_cnt_d = stb_cnt_q;
    end
    stable_d = (stb_cnt_d == STB_W'(SEL_STABLE)) ? sel_s : stable_q;
  end

  assign in_range = (32'(stable_q) < NUM_DESIGNS);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    unique case (state_q)
      SAFE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          if (in_range) begin
            state_d  = ARM;
            cnt_d    = '0;
            active_d = stable_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARM: begin
        if (stable_q != active_q) begin
          state_d = SAFE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (stable_q != active_q) begin
          state_d = SAFE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SAFE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pads and resets decode from the next state so they move on the transition edge.
  always_comb begin
    io_out_d = '0;
    io_oe_d  = '0;
    io_pu_d  = '0;
    io_pd_d  = '1;
    io_cs_d  = '0;
    rstn_d   = '0;
    if (state_d != SAFE) begin
      io_pd_d = '0;
      for (int unsigned d = 0; d < NUM_DESIGNS; d++) begin
        if (active_d == SEL_W'(d)) begin
          io_out_d  = dsn_out[d*NUM_IO +: NUM_IO];
          io_oe_d   = dsn_oe[d*NUM_IO +: NUM_IO];
          io_pu_d   = dsn_pu[d*NUM_IO +: NUM_IO];
          io_pd_d   = dsn_pd[d*NUM_IO +: NUM_IO];
          io_cs_d   = dsn_cs[d*NUM_IO +: NUM_IO];
          rstn_d[d] = (state_d == RUN) & rst_override_n & io_rst_n;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
`ifdef DESIGN_MUX_SEL_SYNC_EN
      sync1_q <= '0;
      sync2_q <= '0;
`endif
      cand_q    <= '0;
      stb_cnt_q <= '0;
      stable_q  <= '0;
      state_q   <= SAFE;
      cnt_q     <= '0;
      active_q  <= '0;
      io_out_q  <= '0;
      io_oe_q   <= '0;
      io_pu_q   <= '0;
      io_pd_q   <= '1;
      io_cs_q   <= '0;
      rstn_q    <= '0;
    end else begin
`ifdef DESIGN_MUX_SEL_SYNC_EN
      sync1_q <= design_sel;
      sync2_q <= sync1_q;
`endif
      cand_q    <= cand_d;
      stb_cnt_q <= stb_cnt_d;
      stable_q  <= stable_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      io_out_q  <= io_out_d;
      io_oe_q   <= io_oe_d;
      io_pu_q   <= io_pu_d;
      io_pd_q   <= io_pd_d;
      io_cs_q   <= io_cs_d;
      rstn_q    <= rstn_d;
    end
  end

  assign io_out       = io_out_q;
  assign io_oe        = io_oe_q;
  assign io_pu        = io_pu_q;
  assign io_pd        = io_pd_q;
  assign io_cs        = io_cs_q;
  assign design_rst_n = rstn_q;
  assign active_sel   = active_q;
  assign busy         = (state_q != RUN);

endmodule

// File: tb/tb_design_mux.sv
// Testbench for design_mux: directed steps plus randomized selects/buses against a timeline model.
module tb_design_mux;
  localparam int NIO = 42;
  localparam int ND  = 6;
  localparam int SW  = 3;
  localparam int SS  = 4;
  localparam int SET = 16;
  localparam int RH  = 8;
`ifdef DESIGN_MUX_SEL_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = SYNC + SS + 1;

  logic clk, rst, ovr, iorst;
  logic [SW-1:0] design_sel;
  logic [ND*NIO-1:0] b_out, b_oe, b_pu, b_pd, b_cs;
  logic [NIO-1:0] io_out, io_oe, io_pu, io_pd, io_cs;
  logic [ND-1:0] design_rst_n;
  logic [SW-1:0] active_sel;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;

  design_mux #(
    .NUM_IO(NIO), .NUM_DESIGNS(ND), .SEL_W(SW),
    .SEL_STABLE(SS), .SETTLE_CYCLES(SET), .RST_HOLD(RH)
  ) dut (
    .clk_i(clk), .rst(rst), .design_sel(design_sel),
    .rst_override_n(ovr), .io_rst_n(iorst),
    .dsn_out(b_out), .dsn_oe(b_oe), .dsn_pu(b_pu), .dsn_pd(b_pd), .dsn_cs(b_cs),
    .io_out(io_out), .io_oe(io_oe), .io_pu(io_pu), .io_pd(io_pd), .io_cs(io_cs),
    .design_rst_n(design_rst_n), .active_sel(active_sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeline model: pad ownership follows from edge timestamps of the last SAFE/ARM entry.
  int e, safe_at, arm_at, m_stable, m_active, v;
  bit in_safe, all_eq;
  int dq[$];
  int vq[$];
  logic [NIO-1:0] x_out, x_oe, x_pu, x_pd, x_cs;
  logic [ND-1:0] x_rstn;
  logic x_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e = 0; safe_at = 0; arm_at = 0; in_safe = 1'b1;
      m_stable = 0; m_active = 0;
      dq.delete(); vq.delete();
    end else begin
      e++;
      dq.push_back(int'(design_sel));
      v = (e > SYNC) ? dq[e-SYNC-1] : 0;
      vq.push_back(v);
      if (in_safe) begin
        if ((e - safe_at >= SET) && (m_stable < ND)) begin
          in_safe = 1'b0; arm_at = e; m_active = m_stable;
        end
      end else if (m_stable != m_active) begin
        in_safe = 1'b1; safe_at = e;
      end
      if (e >= SS) begin
        all_eq = 1'b1;
        for (int k = e - SS; k < e; k++) if (vq[k] != v) all_eq = 1'b0;
        if (all_eq) m_stable = v;
      end
    end
    x_rstn = '0;
    if (in_safe) begin
      x_out = '0; x_oe = '0; x_pu = '0; x_pd = '1; x_cs = '0; x_busy = 1'b1;
    end else begin
      x_out = b_out[m_active*NIO +: NIO];
      x_oe  = b_oe[m_active*NIO +: NIO];
      x_pu  = b_pu[m_active*NIO +: NIO];
      x_pd  = b_pd[m_active*NIO +: NIO];
      x_cs  = b_cs[m_active*NIO +: NIO];
      x_busy = (e - arm_at < RH);
      if (!x_busy) x_rstn[m_active] = ovr & iorst;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":io_out"}, 64'(io_out), 64'(x_out));
    chk({tag, ":io_oe"}, 64'(io_oe), 64'(x_oe));
    chk({tag, ":io_pu"}, 64'(io_pu), 64'(x_pu));
    chk({tag, ":io_pd"}, 64'(io_pd), 64'(x_pd));
    chk({tag, ":io_cs"}, 64'(io_cs), 64'(x_cs));
    chk({tag, ":rst_n"}, 64'(design_rst_n), 64'(x_rstn));
    chk({tag, ":active"}, 64'(active_sel), 64'(m_active));
    chk({tag, ":busy"}, 64'(busy), 64'(x_busy));
  endtask

  function automatic logic [NIO-1:0] pat(input int d);
    logic [NIO-1:0] p;
    logic [2:0] dv;
    dv = 3'(d);
    for (int i = 0; i < NIO; i++) p[i] = dv[i%3];
    return p;
  endfunction

  task automatic set_pattern();
    for (int d = 0; d < ND; d++) begin
      b_out[d*NIO +: NIO] = pat(d);
      b_oe[d*NIO +: NIO]  = '1;
      b_pu[d*NIO +: NIO]  = '0;
      b_pd[d*NIO +: NIO]  = '0;
      b_cs[d*NIO +: NIO]  = ~pat(d);
    end
  endtask

  task automatic rand_buses();
    for (int i = 0; i < ND*NIO; i++) begin
      b_out[i] = 1'($urandom); b_oe[i] = 1'($urandom); b_pu[i] = 1'($urandom);
      b_pd[i]  = 1'($urandom); b_cs[i] = 1'($urandom);
    end
  endtask

  task automatic run(input int n, input string tag, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_model(tag);
      if (rnd) rand_buses();
    end
  endtask

  initial begin
    rst = 1'b1; design_sel = '0; ovr = 1'b1; iorst = 1'b1;
    set_pattern();
    repeat (3) @(negedge clk);
    check_model("reset");
    chk("reset_busy", 64'(busy), 64'd1);
    chk("reset_pd", 64'(io_pd), 64'({NIO{1'b1}}));
    chk("reset_rstn", 64'(design_rst_n), 64'd0);
    rst = 1'b0;

    for (int k = 1; k <= SET + RH; k++) begin
      @(negedge clk);
      check_model("boot");
      if (k == SET + RH - 1) chk("boot_busy_pre", 64'(busy), 64'd1);
    end
    chk("boot_rstn", 64'(design_rst_n), 64'(6'b000001));
    chk("boot_busy", 64'(busy), 64'd0);
    chk("boot_out", 64'(io_out), 64'(pat(0)));

    run(12, "run0_rnd", 1'b1);
    set_pattern();

    design_sel = 3'd3;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check_model("sw3");
      if (k == LAT - 1) chk("sw3_busy_pre", 64'(busy), 64'd0);
    end
    chk("sw3_safe_busy", 64'(busy), 64'd1);
    chk("sw3_safe_oe", 64'(io_oe), 64'd0);
    run(SET, "sw3_safe", 1'b0);
    chk("sw3_arm_oe", 64'(io_oe), 64'({NIO{1'b1}}));
    chk("sw3_arm_rstn", 64'(design_rst_n), 64'd0);
    run(RH, "sw3_arm", 1'b0);
    chk("sw3_rstn", 64'(design_rst_n), 64'(6'b001000));
    chk("sw3_active", 64'(active_sel), 64'd3);

    design_sel = 3'd5;
    run(3, "glitch", 1'b0);
    design_sel = 3'd3;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check_model("glitch");
      chk("glitch_busy", 64'(busy), 64'd0);
    end

    design_sel = 3'd4;
    run(LAT + SET, "abort_pre", 1'b0);
    chk("abort_arm_active", 64'(active_sel), 64'd4);
    chk("abort_arm_oe", 64'(io_oe), 64'({NIO{1'b1}}));
    design_sel = 3'd2;
    run(LAT - 1, "abort_arm", 1'b0);
    chk("abort_still_arm", 64'(io_oe), 64'({NIO{1'b1}}));
    run(1, "abort_safe", 1'b0);
    chk("abort_safe_oe", 64'(io_oe), 64'd0);
    run(SET + RH, "abort_seq", 1'b0);
    chk("abort_active", 64'(active_sel), 64'd2);
    chk("abort_rstn", 64'(design_rst_n), 64'(6'b000100));
    chk("abort_busy", 64'(busy), 64'd0);

    design_sel = 3'd7;
    run(LAT + SET + 20, "oor", 1'b0);
    chk("oor_busy", 64'(busy), 64'd1);
    chk("oor_pd", 64'(io_pd), 64'({NIO{1'b1}}));
    chk("oor_rstn", 64'(design_rst_n), 64'd0);
    design_sel = 3'd1;
    run(LAT, "oor_ret", 1'b0);
    chk("oor_ret_active", 64'(active_sel), 64'd1);
    run(RH, "oor_arm", 1'b0);
    chk("oor_ret_rstn", 64'(design_rst_n), 64'(6'b000010));

    iorst = 1'b0;
    run(1, "iorst", 1'b0);
    chk("iorst_low", 64'(design_rst_n), 64'd0);
    chk("iorst_busy", 64'(busy), 64'd0);
    iorst = 1'b1;
    run(1, "iorst_rel", 1'b0);
    chk("iorst_rel", 64'(design_rst_n), 64'(6'b000010));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_model("rst_pins");
      ovr = 1'($urandom); iorst = 1'($urandom);
    end
    ovr = 1'b1; iorst = 1'b1;

    design_sel = 3'd5;
    run(LAT + SET + 3, "midarm", 1'b0);
    chk("midarm_active", 64'(active_sel), 64'd5);
    chk("midarm_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_model("async_rst");
    chk("async_rst_oe", 64'(io_oe), 64'd0);
    chk("async_rst_active", 64'(active_sel), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(SET + RH + 6, "post_rst", 1'b0);
    chk("post_rst_rstn", 64'(design_rst_n), 64'(6'b100000));

    for (int s = 0; s < 14; s++) begin
      int dur;
      design_sel = 3'($urandom_range(0, 7));
      dur = int'($urandom_range(1, 45));
      for (int k = 0; k < dur; k++) begin
        @(negedge clk);
        check_model("rand");
        rand_buses();
        ovr = ($urandom_range(0, 9) != 0);
        iorst = ($urandom_range(0, 9) != 0);
      end
    end
    design_sel = '0;
    run(LAT + SET + RH + 30, "rand_tail", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
